vga_rx_monitor: RTL and testbench

- Receiving end of the VGA video link: consumes `h_sync`, `v_sync` and `RGB` as produced by the team's 640x480 sync/pixel-gen path.
- Recovers pixel timing and pixel coordinates from the stream.
- Checks line and frame periods, and accumulates a per-frame pixel checksum.
- Sits in loopback on the same clock as the VGA controller; used for self-test and as a frame-capture front end.

---
 rtl/vga_rx_monitor.sv | 189 ++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates from h_sync/v_sync/RGB,
// verifies line and frame periods and publishes a per-frame pixel checksum.
module vga_rx_monitor #(
    parameter int CPP     = 4,
    parameter int H_DISP  = 640,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_TOTAL = 800,
    parameter int V_DISP  = 480,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_TOTAL = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [11:0] RGB,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [11:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        h_locked,
    output logic        v_locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        frame_done,
    output logic [15:0] frame_sum
);

    localparam logic [12:0] LINE_CLKS   = 13'(H_TOTAL * CPP);
    localparam logic [10:0] FRAME_LINES = 11'(V_TOTAL);
    localparam logic [3:0]  PHASE_LAST  = 4'(CPP - 1);
    localparam logic [9:0]  H_START     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_END       = 10'(H_SYNC + H_BACK + H_DISP);
    localparam logic [9:0]  V_START     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END       = 10'(V_SYNC + V_BACK + V_DISP);

    logic        s_hs_r, s_vs_r, prev_hs_r, prev_vs_r;
    logic [11:0] s_rgb_r;
    logic [11:0] clk_cnt_r;
    logic [3:0]  phase_r;
    logic [9:0]  hpos_r, vpos_r;
    logic        h_seen_r, v_seen_r;
    logic [1:0]  h_good_r, v_good_r;
    logic        vs_pending_r;
    logic        taint_r;
    logic [15:0] acc_r;

    logic        hs_fall_s, vs_fall_s, frame_edge_s;
    logic        line_ok_s, frame_ok_s, line_mis_s, capture_s;
    logic [15:0] acc_next_s;

    // Edge detection, period comparisons, capture window and checksum update
    always_comb begin
        hs_fall_s    = prev_hs_r & ~s_hs_r;
        vs_fall_s    = prev_vs_r & ~s_vs_r;
        frame_edge_s = hs_fall_s & (vs_pending_r | vs_fall_s);
        line_ok_s    = (({1'b0, clk_cnt_r} + 13'd1) == LINE_CLKS);
        frame_ok_s   = (({1'b0, vpos_r} + 11'd1) == FRAME_LINES);
        line_mis_s   = hs_fall_s & h_seen_r & ~line_ok_s;
        capture_s    = (phase_r == 4'd0) &&
                       (hpos_r >= H_START) && (hpos_r < H_END) &&
                       (vpos_r >= V_START) && (vpos_r < V_END);
        if (pixel_valid) begin
            acc_next_s = acc_r + {4'd0, pixel_rgb};
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Input sampling, timing recovery, lock qualification and frame publication
    always_ff @(posedge clk) begin
        if (reset) begin
            s_hs_r       <= 1'b1;
            s_vs_r       <= 1'b1;
            prev_hs_r    <= 1'b1;
            prev_vs_r    <= 1'b1;
            s_rgb_r      <= 12'd0;
            clk_cnt_r    <= 12'd0;
            phase_r      <= 4'd0;
            hpos_r       <= 10'd0;
            vpos_r       <= 10'd0;
            h_seen_r     <= 1'b0;
            v_seen_r     <= 1'b0;
            h_good_r     <= 2'd0;
            v_good_r     <= 2'd0;
            vs_pending_r <= 1'b0;
            taint_r      <= 1'b0;
            acc_r        <= 16'd0;
            pixel_x      <= 10'd0;
            pixel_y      <= 10'd0;
            pixel_rgb    <= 12'd0;
            pixel_valid  <= 1'b0;
            h_locked     <= 1'b0;
            v_locked     <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
            frame_done   <= 1'b0;
            frame_sum    <= 16'd0;
        end else begin
            s_hs_r     <= h_sync;
            s_vs_r     <= v_sync;
            prev_hs_r  <= s_hs_r;
            prev_vs_r  <= s_vs_r;
            s_rgb_r    <= RGB;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;

            if (hs_fall_s) begin
                clk_cnt_r <= 12'd0;
                phase_r   <= 4'd0;
                hpos_r    <= 10'd0;
                if (!h_seen_r) begin
                    h_seen_r <= 1'b1;
                end else if (line_ok_s) begin
                    if (h_good_r != 2'd2) begin
                        h_good_r <= h_good_r + 2'd1;
                    end
                    if (h_good_r != 2'd0) begin
                        h_locked <= 1'b1;
                    end
                end else begin
                    line_err <= 1'b1;
                    h_locked <= 1'b0;
                    h_good_r <= 2'd0;
                end
            end else begin
                if (clk_cnt_r != 12'hFFF) begin
                    clk_cnt_r <= clk_cnt_r + 12'd1;
                end
                if (phase_r == PHASE_LAST) begin
                    phase_r <= 4'd0;
                    if (hpos_r != 10'h3FF) begin
                        hpos_r <= hpos_r + 10'd1;
                    end
                end else begin
                    phase_r <= phase_r + 4'd1;
                end
            end

            // A frame that saw a bad line carries an incomplete sum, so it is never published
            if (frame_edge_s) begin
                vs_pending_r <= 1'b0;
                vpos_r       <= 10'd0;
                acc_r        <= 16'd0;
                taint_r      <= 1'b0;
                if (!v_seen_r) begin
                    v_seen_r <= 1'b1;
                end else if (frame_ok_s) begin
                    if (v_locked && !taint_r && !line_mis_s) begin
                        frame_sum  <= acc_next_s;
                        frame_done <= 1'b1;
                    end
                    if (v_good_r != 2'd2) begin
                        v_good_r <= v_good_r + 2'd1;
                    end
                    if (v_good_r != 2'd0) begin
                        v_locked <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                    v_locked  <= 1'b0;
                    v_good_r  <= 2'd0;
                end
            end else begin
                if (vs_fall_s) begin
                    vs_pending_r <= 1'b1;
                end
                if (hs_fall_s && (vpos_r != 10'h3FF)) begin
                    vpos_r <= vpos_r + 10'd1;
                end
                if (line_mis_s) begin
                    taint_r <= 1'b1;
                end
                acc_r <= acc_next_s;
            end

            pixel_valid <= capture_s & h_locked & v_locked;
            if (capture_s && h_locked && v_locked) begin
                pixel_x   <= hpos_r - H_START;
                pixel_y   <= vpos_r - V_START;
                pixel_rgb <= s_rgb_r;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor on a reduced video geometry: a line-level
// reference model queues expected pixels, sums and error strobes; a monitor checks them.
module tb_vga_rx_monitor;

    localparam int CPP  = 4;
    localparam int HD   = 10;
    localparam int HS   = 3;
    localparam int HB   = 2;
    localparam int HT   = 20;
    localparam int VD   = 6;
    localparam int VS   = 2;
    localparam int VB   = 3;
    localparam int VT   = 14;
    localparam int LINE = HT * CPP;

    logic        clk = 1'b0;
    logic        reset, h_sync, v_sync;
    logic [11:0] rgb;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] pixel_rgb;
    logic        pixel_valid, h_locked, v_locked, line_err, frame_err, frame_done;
    logic [15:0] frame_sum;

    vga_rx_monitor #(
        .CPP(CPP), .H_DISP(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISP(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync), .RGB(rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
        .pixel_valid(pixel_valid), .h_locked(h_locked), .v_locked(v_locked),
        .line_err(line_err), .frame_err(frame_err), .frame_done(frame_done),
        .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
    } pix_t;

    pix_t        pix_q[$];
    logic [15:0] done_q[$];
    int          exp_line_err = 0;
    int          exp_frame_err = 0;
    int          n_vec = 0;
    int          n_mis = 0;

    // line-level reference model state
    bit          m_h_seen, m_v_seen, m_h_lock, m_v_lock, m_taint;
    int          m_h_good, m_v_good, m_nlines, prev_len;
    logic [15:0] m_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({pixel_x, pixel_y, pixel_rgb, pixel_valid, h_locked, v_locked,
                    line_err, frame_err, frame_done, frame_sum});
    endfunction

    task automatic model_reset();
        m_h_seen = 1'b0; m_v_seen = 1'b0; m_h_lock = 1'b0; m_v_lock = 1'b0;
        m_taint  = 1'b0; m_h_good = 0;    m_v_good = 0;    m_nlines = 0;
        m_acc    = 16'd0;
    endtask

    // Called at the start of every line: judges the line that just ended and,
    // on line 0, the frame that just ended.
    task automatic model_line_start(input int line);
        bit mis;
        mis = 1'b0;
        if (!m_h_seen) begin
            m_h_seen = 1'b1;
        end else if (prev_len == LINE) begin
            if (m_h_good < 2) m_h_good++;
            if (m_h_good == 2) m_h_lock = 1'b1;
        end else begin
            exp_line_err++;
            m_h_lock = 1'b0;
            m_h_good = 0;
            mis      = 1'b1;
        end
        if (line == 0) begin
            if (!m_v_seen) begin
                m_v_seen = 1'b1;
            end else if (m_nlines == VT) begin
                if (m_v_lock && !m_taint && !mis) done_q.push_back(m_acc);
                if (m_v_good < 2) m_v_good++;
                if (m_v_good == 2) m_v_lock = 1'b1;
            end else begin
                exp_frame_err++;
                m_v_lock = 1'b0;
                m_v_good = 0;
            end
            m_nlines = 1;
            m_acc    = 16'd0;
            m_taint  = 1'b0;
        end else begin
            m_nlines++;
            if (mis) m_taint = 1'b1;
        end
    endtask

    // mode 0: solid 12'h001, 1: ramp with x in the low nibble, 2: random colour
    task automatic send_line(input int line, input int len, input int mode, input bit rst_here);
        logic [11:0] col;
        col = 12'd0;
        model_line_start(line);
        for (int c = 0; c < len; c++) begin
            int h;
            bit active;
            @(negedge clk);
            h = c / CPP;
            if (c % CPP == 0) begin
                active = (line >= VS + VB) && (line < VS + VB + VD) &&
                         (h >= HS + HB) && (h < HS + HB + HD);
                if (active) begin
                    case (mode)
                        0:       col = 12'h001;
                        1:       col = {8'($urandom_range(0, 255)), 4'(h - HS - HB)};
                        default: col = 12'($urandom);
                    endcase
                    if (m_h_lock && m_v_lock) begin
                        pix_q.push_back('{x: h - HS - HB, y: line - VS - VB, rgb: col});
                        m_acc = m_acc + {4'd0, col};
                    end
                end else begin
                    col = 12'($urandom);
                end
            end
            h_sync = (h < HS) ? 1'b0 : 1'b1;
            v_sync = (line < VS) ? 1'b0 : 1'b1;
            rgb    = col;
            if (rst_here && c == HS * CPP + 1) begin
                reset = 1'b1;
                model_reset();
            end
            if (rst_here && c == HS * CPP + 2) begin
                reset = 1'b0;
                check("outputs_after_midframe_reset", all_outputs(), 64'd0);
            end
            if (c == len / 2) begin
                check("h_locked", 64'(h_locked), 64'(m_h_lock));
                check("v_locked", 64'(v_locked), 64'(m_v_lock));
            end
        end
        prev_len = len;
    endtask

    task automatic send_frame(input int nlines, input int mode, input int short_line, input int rst_line);
        for (int l = 0; l < nlines; l++) begin
            send_line(l, (l == short_line) ? LINE - 4 : LINE, mode, l == rst_line);
        end
    endtask

    // Monitor: every strobe the DUT raises must match the next queued expectation
    always @(negedge clk) begin : monitor
        pix_t p;
        if (pixel_valid) begin
            check("pixel_expected", 64'(pix_q.size() != 0), 64'd1);
            if (pix_q.size() != 0) begin
                p = pix_q.pop_front();
                check("pixel_x", 64'(pixel_x), 64'(p.x));
                check("pixel_y", 64'(pixel_y), 64'(p.y));
                check("pixel_rgb", 64'(pixel_rgb), 64'(p.rgb));
                check("ramp_low_nibble", 64'(pixel_rgb[3:0] == p.rgb[3:0]), 64'd1);
            end
        end
        if (frame_done) begin
            check("frame_done_expected", 64'(done_q.size() != 0), 64'd1);
            if (done_q.size() != 0) check("frame_sum", 64'(frame_sum), 64'(done_q.pop_front()));
        end
        if (line_err) begin
            check("line_err_expected", 64'(exp_line_err > 0), 64'd1);
            if (exp_line_err > 0) exp_line_err--;
        end
        if (frame_err) begin
            check("frame_err_expected", 64'(exp_frame_err > 0), 64'd1);
            if (exp_frame_err > 0) exp_frame_err--;
        end
    end

    initial begin
        int sl, rl;
        reset  = 1'b1;
        h_sync = 1'b1;
        v_sync = 1'b1;
        rgb    = 12'd0;
        prev_len = 0;
        model_reset();
        repeat (5) @(negedge clk);
        check("outputs_in_reset", all_outputs(), 64'd0);
        reset = 1'b0;
        repeat (10000) @(negedge clk);
        check("outputs_after_idle", all_outputs(), 64'd0);

        repeat (5) send_frame(VT, 0, -1, -1);
        repeat (2) send_frame(VT, 1, -1, -1);

        sl = $urandom_range(VS + VB, VS + VB + VD - 1);
        send_frame(VT, 2, sl, -1);
        repeat (3) send_frame(VT, 2, -1, -1);

        send_frame(VT - 1, 2, -1, -1);
        repeat (4) send_frame(VT, 2, -1, -1);

        rl = $urandom_range(VS + VB, VS + VB + VD - 1);
        send_frame(VT, 0, -1, rl);
        repeat (5) send_frame(VT, 0, -1, -1);

        @(negedge clk);
        h_sync = 1'b1;
        v_sync = 1'b1;
        repeat (200) @(negedge clk);
        check("pixels_outstanding", 64'(pix_q.size()), 64'd0);
        check("frame_sums_outstanding", 64'(done_q.size()), 64'd0);
        check("line_err_outstanding", 64'(exp_line_err), 64'd0);
        check("frame_err_outstanding", 64'(exp_frame_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
